// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen_if
// Purpose  : Raster coordinates, sync pins and timing strobes of vga_sync_gen.
// Revision : 1.0
// ============================================================================
interface vga_sync_gen_if;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       p_tick;
  logic       frame_tick;

  modport master (
    output pix_x, pix_y, video_on, hsync, vsync, p_tick, frame_tick
  );

  modport slave (
    input  pix_x, pix_y, video_on, hsync, vsync, p_tick, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Purpose  : 640x480@60 raster timing generator with an internal pixel divider.
// Revision : 1.0
// ============================================================================
module vga_sync_gen #(
  parameter int DIV       = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);
  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] H_VIS_LAST = 10'(H_DISPLAY - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(V_DISPLAY - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic             r_hsync;
  logic             r_vsync;

  logic [9:0]       w_h_next;
  logic [9:0]       w_v_next;
  logic             w_p_tick;
  logic             w_h_wrap;

  always_comb begin
    w_p_tick = (r_div_cnt == DIV_LAST);
    w_h_wrap = w_p_tick && (r_h == H_LAST);
    w_h_next = r_h;
    w_v_next = r_v;
    if (w_p_tick) begin
      w_h_next = w_h_wrap ? 10'd0 : r_h + 10'd1;
    end
    if (w_h_wrap) begin
      w_v_next = (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
    end
  end

  // Sync pins decode the next coordinate so they switch on the same edge as pix_x/pix_y.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
      r_h       <= '0;
      r_v       <= '0;
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
    end else begin
      r_div_cnt <= w_p_tick ? '0 : r_div_cnt + DIV_W'(1);
      r_h       <= w_h_next;
      r_v       <= w_v_next;
      r_hsync   <= !((w_h_next >= HS_FIRST) && (w_h_next <= HS_LAST));
      r_vsync   <= !((w_v_next >= VS_FIRST) && (w_v_next <= VS_LAST));
    end
  end

  assign vga.pix_x      = r_h;
  assign vga.pix_y      = r_v;
  assign vga.video_on   = (r_h < H_VIS) && (r_v < V_VIS);
  assign vga.hsync      = r_hsync;
  assign vga.vsync      = r_vsync;
  assign vga.p_tick     = w_p_tick;
  assign vga.frame_tick = w_p_tick && (r_h == H_VIS_LAST) && (r_v == V_VIS_LAST);
endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen
// Purpose  : Directed self-checking bench for vga_sync_gen (full-size and reduced geometry).
// Revision : 1.0
// ============================================================================
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if vif_a ();
  vga_sync_gen_if vif_b ();

  vga_sync_gen dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (vif_a)
  );

  // Reduced raster: H_TOTAL = 15, V_TOTAL = 9, DIV = 2 -> frame of 270 clks.
  vga_sync_gen #(
    .DIV(2), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISPLAY(4), .V_FP(2), .V_SYNC(2), .V_BP(1)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (vif_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check_val({tag, "_x"},    32'(vif_a.pix_x),      0);
    check_val({tag, "_y"},    32'(vif_a.pix_y),      0);
    check_val({tag, "_hs"},   32'(vif_a.hsync),      1);
    check_val({tag, "_vs"},   32'(vif_a.vsync),      1);
    check_val({tag, "_von"},  32'(vif_a.video_on),   1);
    check_val({tag, "_pt"},   32'(vif_a.p_tick),     0);
    check_val({tag, "_ft"},   32'(vif_a.frame_tick), 0);
  endtask

  // Full-size instance trackers
  int prev_x, prev_hs, wrap1, wrap2, y_after_wrap, hs_fall, hs_fall_x, hs_rise;
  // Reduced instance trackers
  int pb_x, pb_y, pb_vs, pb_ft, pb_pt;
  int n_ft, ft_wide, t_ft1, t_ft2, ft1_x, ft1_y, n_von, n_pt, pt_double;
  int vs_fall, vs_rise, vs_fall_x, vs_fall_y, wrap_seen, wrap_hs, wrap_vs, von_8_0, von_0_4;

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_a("rst");

    // ---------------- full-size: first tick, line and hsync timing ----------------
    prev_x = -1; prev_hs = 1; wrap1 = -1; wrap2 = -1; y_after_wrap = -1;
    hs_fall = -1; hs_fall_x = -1; hs_rise = -1;
    rst_a = 1'b1;
    for (int k = 0; k < 7000; k++) begin
      @(negedge clk);
      if (k == 1) check_val("tick_e1", 32'(vif_a.p_tick), 0);
      if (k == 2) begin
        check_val("tick_e2", 32'(vif_a.p_tick), 1);
        check_val("x_e2",    32'(vif_a.pix_x),  0);
      end
      if (k == 3) begin
        check_val("x_e3",    32'(vif_a.pix_x),  1);
        check_val("tick_e3", 32'(vif_a.p_tick), 0);
      end
      if (prev_x == 799 && int'(vif_a.pix_x) == 0) begin
        if (wrap1 < 0) begin
          wrap1 = k;
          y_after_wrap = int'(vif_a.pix_y);
        end else if (wrap2 < 0) begin
          wrap2 = k;
        end
      end
      if (prev_hs == 1 && vif_a.hsync == 1'b0 && hs_fall < 0) begin
        hs_fall = k;
        hs_fall_x = int'(vif_a.pix_x);
      end
      if (hs_fall >= 0 && prev_hs == 0 && vif_a.hsync == 1'b1 && hs_rise < 0) hs_rise = k;
      prev_x  = int'(vif_a.pix_x);
      prev_hs = int'(vif_a.hsync);
    end
    check_val("line_period", 32'(wrap2 - wrap1), 3200);
    check_val("y_after_wrap", 32'(y_after_wrap), 1);
    check_val("hs_fall_x", 32'(hs_fall_x), 656);
    check_val("hs_low_clks", 32'(hs_rise - hs_fall), 384);

    // ---------------- full-size: asynchronous mid-line reset ----------------
    for (int k = 0; k < 4000 && vif_a.pix_x != 10'd300; k++) @(negedge clk);
    check_val("reach_x300", 32'(vif_a.pix_x), 300);
    check_val("pre_rst_y",  32'(vif_a.pix_y), 2);
    #2 rst_a = 1'b0;
    #1 check_reset_a("async");
    @(negedge clk);
    check_reset_a("held");
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rs_tick_e2", 32'(vif_a.p_tick), 1);
    check_val("rs_x_e2",    32'(vif_a.pix_x),  0);
    @(negedge clk);
    check_val("rs_x_e3",    32'(vif_a.pix_x),  1);

    // ---------------- reduced geometry: frame-level behaviour ----------------
    pb_x = -1; pb_y = -1; pb_vs = 1; pb_ft = 0; pb_pt = 0;
    n_ft = 0; ft_wide = 0; t_ft1 = -1; t_ft2 = -1; ft1_x = -1; ft1_y = -1;
    n_von = 0; n_pt = 0; pt_double = 0;
    vs_fall = -1; vs_rise = -1; vs_fall_x = -1; vs_fall_y = -1;
    wrap_seen = 0; wrap_hs = -1; wrap_vs = -1; von_8_0 = -1; von_0_4 = -1;
    rst_b = 1'b1;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (vif_b.frame_tick) begin
        n_ft++;
        if (pb_ft == 1) ft_wide++;
        if (t_ft1 < 0) begin
          t_ft1 = i;
          ft1_x = int'(vif_b.pix_x);
          ft1_y = int'(vif_b.pix_y);
        end else if (t_ft2 < 0) begin
          t_ft2 = i;
        end
      end
      if (t_ft1 >= 0 && t_ft2 < 0) begin
        n_von += int'(vif_b.video_on);
        n_pt  += int'(vif_b.p_tick);
      end
      if (pb_pt == 1 && vif_b.p_tick == 1'b1) pt_double++;
      if (pb_vs == 1 && vif_b.vsync == 1'b0 && vs_fall < 0) begin
        vs_fall   = i;
        vs_fall_x = int'(vif_b.pix_x);
        vs_fall_y = int'(vif_b.pix_y);
      end
      if (vs_fall >= 0 && pb_vs == 0 && vif_b.vsync == 1'b1 && vs_rise < 0) vs_rise = i;
      if (pb_x == 14 && pb_y == 8 && !(vif_b.pix_x == 10'd14 && vif_b.pix_y == 10'd8) && wrap_seen == 0) begin
        wrap_seen = (vif_b.pix_x == 10'd0 && vif_b.pix_y == 10'd0) ? 1 : 2;
        wrap_hs   = int'(vif_b.hsync);
        wrap_vs   = int'(vif_b.vsync);
      end
      if (vif_b.pix_x == 10'd8 && vif_b.pix_y == 10'd0 && von_8_0 < 0) von_8_0 = int'(vif_b.video_on);
      if (vif_b.pix_x == 10'd0 && vif_b.pix_y == 10'd4 && von_0_4 < 0) von_0_4 = int'(vif_b.video_on);
      pb_x  = int'(vif_b.pix_x);
      pb_y  = int'(vif_b.pix_y);
      pb_vs = int'(vif_b.vsync);
      pb_ft = int'(vif_b.frame_tick);
      pb_pt = int'(vif_b.p_tick);
    end
    check_val("ft_count",     32'(n_ft), 3);
    check_val("ft_wide",      32'(ft_wide), 0);
    check_val("ft_x",         32'(ft1_x), 7);
    check_val("ft_y",         32'(ft1_y), 3);
    check_val("frame_period", 32'(t_ft2 - t_ft1), 270);
    check_val("von_clks",     32'(n_von), 64);
    check_val("pt_per_frame", 32'(n_pt), 135);
    check_val("pt_double",    32'(pt_double), 0);
    check_val("vs_fall_x",    32'(vs_fall_x), 0);
    check_val("vs_fall_y",    32'(vs_fall_y), 6);
    check_val("vs_low_clks",  32'(vs_rise - vs_fall), 60);
    check_val("wrap_to_00",   32'(wrap_seen), 1);
    check_val("wrap_hs",      32'(wrap_hs), 1);
    check_val("wrap_vs",      32'(wrap_vs), 1);
    check_val("von_8_0",      32'(von_8_0), 0);
    check_val("von_0_4",      32'(von_0_4), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
